// File: rtl/cordic_stage_if.sv
// Handshake/state bundle between a CORDIC iteration controller (master) and one registered stage (slave).
interface cordic_stage_if #(
    parameter int unsigned p_WIDTH   = 32,
    parameter int unsigned p_SHIFT_W = 5
);
    logic                 i_valid;
    logic [p_WIDTH-1:0]   i_xprev;
    logic [p_WIDTH-1:0]   i_yprev;
    logic [p_WIDTH-1:0]   i_zprev;
    logic                 i_dprev;
    logic                 i_mode;
    logic [p_WIDTH-1:0]   i_lut;
    logic [p_SHIFT_W-1:0] i_shift_amnt;

    logic [p_WIDTH-1:0]   o_xnext;
    logic [p_WIDTH-1:0]   o_ynext;
    logic [p_WIDTH-1:0]   o_znext;
    logic                 o_dnext;
    logic                 o_valid;

    modport master (
        output i_valid, i_xprev, i_yprev, i_zprev, i_dprev, i_mode, i_lut, i_shift_amnt,
        input  o_xnext, o_ynext, o_znext, o_dnext, o_valid
    );

    modport slave (
        input  i_valid, i_xprev, i_yprev, i_zprev, i_dprev, i_mode, i_lut, i_shift_amnt,
        output o_xnext, o_ynext, o_znext, o_dnext, o_valid
    );
endinterface

// File: rtl/cordic_stage.sv
// One registered CORDIC iteration (circular/linear, rotation mode) with 1-cycle latency.
// Optional macro CORDIC_SATURATE_EN: x/y saturate on signed overflow instead of wrapping.
module cordic_stage #(
    parameter int unsigned p_WIDTH   = 32,
    parameter int unsigned p_SHIFT_W = 5
) (
    input  logic           i_clk,
    input  logic           i_rst,
    cordic_stage_if.slave  bus
);
    localparam int unsigned W = p_WIDTH;

    // x/y add-subtract; z never goes through here because angle wrap is legal
    function automatic logic [W-1:0] add_xy(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sub);
`ifdef CORDIC_SATURATE_EN
        logic [W:0] sum;
        sum = sub ? ({a[W-1], a} - {b[W-1], b}) : ({a[W-1], a} + {b[W-1], b});
        if (sum[W] != sum[W-1])
            return sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        return sum[W-1:0];
`else
        return sub ? (a - b) : (a + b);
`endif
    endfunction

    logic [p_SHIFT_W-1:0] shift_c;
    logic signed [W-1:0]  xs_c;
    logic signed [W-1:0]  ys_c;
    logic [W-1:0]         xn_c;
    logic [W-1:0]         yn_c;
    logic [W-1:0]         zn_c;

    assign shift_c = bus.i_shift_amnt;

    always_comb begin
        xs_c = '0;
        ys_c = '0;
        xn_c = bus.i_xprev;
        yn_c = bus.i_yprev;
        zn_c = bus.i_zprev;

        // Oversized shifts collapse to pure sign extension
        if (32'(shift_c) >= W) begin
            xs_c = {W{bus.i_xprev[W-1]}};
            ys_c = {W{bus.i_yprev[W-1]}};
        end else begin
            xs_c = $signed(bus.i_xprev) >>> shift_c;
            ys_c = $signed(bus.i_yprev) >>> shift_c;
        end

        if (bus.i_mode)
            xn_c = add_xy(bus.i_xprev, ys_c, bus.i_dprev);
        yn_c = add_xy(bus.i_yprev, xs_c, ~bus.i_dprev);
        zn_c = bus.i_dprev ? (bus.i_zprev - bus.i_lut) : (bus.i_zprev + bus.i_lut);
    end

    // Output registers; reset wins over a valid input on the same edge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_xnext <= '0;
            bus.o_ynext <= '0;
            bus.o_znext <= '0;
            bus.o_dnext <= 1'b1;
            bus.o_valid <= 1'b0;
        end else begin
            bus.o_valid <= bus.i_valid;
            if (bus.i_valid) begin
                bus.o_xnext <= xn_c;
                bus.o_ynext <= yn_c;
                bus.o_znext <= zn_c;
                bus.o_dnext <= ~zn_c[W-1];
            end
        end
    end
endmodule

// File: tb/tb_cordic_stage.sv
// Self-checking bench for cordic_stage: directed vectors, then random stimulus against an integer model.
module tb_cordic_stage;
    localparam int unsigned W  = 32;
    localparam int unsigned SW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cordic_stage_if #(.p_WIDTH(W), .p_SHIFT_W(SW)) bus ();
    cordic_stage #(.p_WIDTH(W), .p_SHIFT_W(SW)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] ex, ey, ez;
    logic        ed, ev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".x"}, bus.o_xnext, ex);
        chk({tag, ".y"}, bus.o_ynext, ey);
        chk({tag, ".z"}, bus.o_znext, ez);
        chk({tag, ".d"}, {31'b0, bus.o_dnext}, {31'b0, ed});
        chk({tag, ".valid"}, {31'b0, bus.o_valid}, {31'b0, ev});
    endtask

    function automatic logic [31:0] fit_xy(input longint v);
`ifdef CORDIC_SATURATE_EN
        if (v > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (v < -64'sd2147483648) return 32'h8000_0000;
`endif
        return 32'(v);
    endfunction

    // Rotation rules with wide integers; wrap/saturate applied only at the end
    task automatic model(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                         input logic d, input logic mode, input logic [31:0] lut,
                         input int unsigned s,
                         output logic [31:0] nx, output logic [31:0] ny,
                         output logic [31:0] nz, output logic nd);
        longint xl, yl, zl, ll, xs, ys;
        xl = longint'($signed(x));
        yl = longint'($signed(y));
        zl = longint'($signed(z));
        ll = longint'($signed(lut));
        xs = (s >= W) ? (xl < 0 ? -64'sd1 : 64'sd0) : (xl >>> s);
        ys = (s >= W) ? (yl < 0 ? -64'sd1 : 64'sd0) : (yl >>> s);
        if (mode) nx = fit_xy(d ? xl - ys : xl + ys);
        else      nx = x;
        ny = fit_xy(d ? yl + xs : yl - xs);
        nz = 32'(d ? zl - ll : zl + ll);
        nd = ~nz[31];
    endtask

    // Drive one cycle of inputs, advance expectations, sample 1 time unit after the edge
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                        input logic d, input logic mode, input logic [31:0] lut,
                        input int unsigned s);
        logic [31:0] nx, ny, nz;
        logic nd;
        rst              = r;
        bus.i_valid      = v;
        bus.i_xprev      = x;
        bus.i_yprev      = y;
        bus.i_zprev      = z;
        bus.i_dprev      = d;
        bus.i_mode       = mode;
        bus.i_lut        = lut;
        bus.i_shift_amnt = SW'(s);
        model(x, y, z, d, mode, lut, s, nx, ny, nz, nd);
        if (r) begin
            ex = '0; ey = '0; ez = '0; ed = 1'b1; ev = 1'b0;
        end else if (v) begin
            ex = nx; ey = ny; ez = nz; ed = nd; ev = 1'b1;
        end else begin
            ev = 1'b0;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] rx, ry, rz, rl;
        logic rd, rm, rv, rr;
        int unsigned rs;

        ex = '0; ey = '0; ez = '0; ed = 1'b1; ev = 1'b0;

        // Reset with valid asserted
        step("reset0", 1'b1, 1'b1, 32'h1234_5678, 32'h1, 32'h2, 1'b1, 1'b1, 32'h3, 0);
        step("reset1", 1'b1, 1'b1, 32'h0FFF_FFFF, 32'h0, 32'h2000_0000, 1'b0, 1'b1, 32'h4, 3);
        chk("reset_lit.d", {31'b0, bus.o_dnext}, 32'd1);

        step("circ_s0", 1'b0, 1'b1, 32'h0FFF_FFFF, 32'h0, 32'h2000_0000, 1'b1, 1'b1, 32'h2000_0000, 0);
        chk("circ_s0_lit.y", bus.o_ynext, 32'h0FFF_FFFF);
        step("circ_s1", 1'b0, 1'b1, ex, ey, ez, ed, 1'b1, 32'h12E4_051E, 1);
        chk("circ_s1_lit.x", bus.o_xnext, 32'h0800_0000);
        chk("circ_s1_lit.y", bus.o_ynext, 32'h17FF_FFFE);
        chk("circ_s1_lit.z", bus.o_znext, 32'hED1B_FAE2);
        chk("circ_s1_lit.d", {31'b0, bus.o_dnext}, 32'd0);

        step("circ_d0", 1'b0, 1'b1, 32'h1000_0000, 32'h1000_0000, 32'h0, 1'b0, 1'b1, 32'h0FAD_BAFC, 2);
        chk("circ_d0_lit.x", bus.o_xnext, 32'h1400_0000);
        chk("circ_d0_lit.y", bus.o_ynext, 32'h0C00_0000);

        step("linear", 1'b0, 1'b1, 32'h4000_0000, 32'h0, 32'h4000_0000, 1'b1, 1'b0, 32'h4000_0000, 1);
        chk("linear_lit.y", bus.o_ynext, 32'h2000_0000);

        step("ovf", 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 1'b1, 1'b1, 32'h0, 0);
`ifdef CORDIC_SATURATE_EN
        chk("ovf_lit.x", bus.o_xnext, 32'h7FFF_FFFF);
`else
        chk("ovf_lit.x", bus.o_xnext, 32'hFFFF_FFFF);
`endif

        // Idle cycles hold outputs with different inputs on the bus
        step("hold0", 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1, 32'h2, 1'b0, 1'b0, 32'h5, 7);
        step("hold1", 1'b0, 1'b0, 32'h0BAD_F00D, 32'h3, 32'h4, 1'b1, 1'b1, 32'h6, 31);

        // Extreme shift and a mid-sequence reset followed by normal operation
        step("shift31", 1'b0, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 31);
        step("midrst", 1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222, 32'h3, 1'b1, 1'b1, 32'h4, 4);
        step("postrst", 1'b0, 1'b1, 32'h1111_1111, 32'h2222_2222, 32'h3, 1'b1, 1'b1, 32'h4, 4);

        for (int i = 0; i < 300; i++) begin
            rx = $urandom(); ry = $urandom(); rz = $urandom(); rl = $urandom();
            rd = 1'($urandom_range(0, 1));
            rm = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 9) < 7);
            rr = ($urandom_range(0, 39) == 0);
            rs = $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) begin
                rx = ex; ry = ey; rz = ez; rd = ed;
            end
            step($sformatf("rand%0d", i), rr, rv, rx, ry, rz, rd, rm, rl, rs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cordic_stage.md
Name: cordic_stage

Overview:
- One registered iteration of a 32-bit fixed-point CORDIC datapath, rotation-driven (z steered toward 0).
- Takes the previous (x, y, z, d) state, an externally supplied arctan/LUT constant and a shift amount.
- Produces the next state one clock later.
- An external controller chains iterations by feeding outputs back and incrementing i_shift_amnt and the LUT index each cycle.

Parameters:
p_WIDTH, 32, datapath width of x, y, z and LUT (two's complement, ≥ 8)
p_SHIFT_W, 5, width of i_shift_amnt (must cover 0..p_WIDTH-1)

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst  in  1  reset, synchronous, active-high
i_valid  in  1  input state is valid; captured this edge
i_xprev  in  p_WIDTH  previous x, signed
i_yprev  in  p_WIDTH  previous y, signed
i_zprev  in  p_WIDTH  previous residual angle, signed; full scale 2^p_WIDTH = 2π (0x20000000 = π/4)
i_dprev  in  1  rotation direction for this iteration: 1 = positive (z ≥ 0), 0 = negative
i_mode  in  1  1 = circular, 0 = linear
i_lut  in  p_WIDTH  angle constant for this iteration (circular: atan(2^-s)·2^31/π; linear: 2^-s in z scale)
i_shift_amnt  in  p_SHIFT_W  iteration index s
o_xnext  out  p_WIDTH  next x
o_ynext  out  p_WIDTH  next y
o_znext  out  p_WIDTH  next z
o_dnext  out  1  direction for next iteration
o_valid  out  1  outputs hold a freshly computed state

Behaviour:
- Shifts are arithmetic (sign-preserving): xs = i_xprev >>> s, ys = i_yprev >>> s. Shift amounts ≥ p_WIDTH yield all-sign bits.
- Circular, d=1: x' = x − ys; y' = y + xs; z' = z − lut.
- Circular, d=0: x' = x + ys; y' = y − xs; z' = z + lut.
- Linear, d=1: x' = x; y' = y + xs; z' = z − lut.
- Linear, d=0: x' = x; y' = y − xs; z' = z + lut.
- All adds/subtracts are modulo 2^p_WIDTH (wrap) unless CORDIC_SATURATE_EN is defined. z always wraps, since angle wrap is legal.
- Direction: o_dnext = ~z'[p_WIDTH-1], i.e. 1 when the new z ≥ 0.
- Latency: exactly 1 cycle. When i_valid=1 at an edge, o_* are loaded with computed values and o_valid=1 at that edge.
- When i_valid=0, o_x/o_y/o_z/o_dnext hold their last values and o_valid=0.
- Gain: no scale compensation; the caller handles K≈1.6468 (circular).
- Reset (i_rst=1 at an edge): o_xnext=o_ynext=o_znext=0, o_dnext=1, o_valid=0. Reset has priority over i_valid, including mid-sequence; the following cycle's inputs are processed normally.
- Mode and shift may change every cycle; no internal state other than the output registers.
- Back-to-back valid inputs are accepted every cycle; no stall.

Optional Feature:
- Macro CORDIC_SATURATE_EN.
- Defined: x' and y' saturate on signed overflow to 0x7FFFFFFF / 0x80000000 (p_WIDTH-scaled).
- Not defined: x' and y' wrap modulo 2^p_WIDTH.
- z wraps in both cases.

Test Plan:
- Reset: assert i_rst one edge with i_valid=1 → o_x/y/z=0, o_dnext=1, o_valid=0.
- Circular s=0: x=0x0FFFFFFF, y=0, z=0x20000000, d=1, lut=0x20000000, valid → next edge: x'=0x0FFFFFFF, y'=0x0FFFFFFF, z'=0, o_dnext=1, o_valid=1.
- Circular s=1, chained: feed back the previous result with lut=0x12E4051E, d=1 → x'=0x08000000, y'=0x17FFFFFE, z'=0xED1BFAE2, o_dnext=0.
- Circular d=0: x=0x10000000, y=0x10000000, z=0, s=2, lut=0x0FADBAFC → x'=0x14000000, y'=0x0C000000, z'=0x0FADBAFC, o_dnext=1.
- Linear: mode=0, x=0x40000000, y=0, s=1, d=1, lut=0x40000000, z=0x40000000 → x'=0x40000000, y'=0x20000000, z'=0.
- Overflow: x=0x7FFFFFFF, y=0x80000000, s=0, d=1, circular → wrap build: x'=0xFFFFFFFF; with CORDIC_SATURATE_EN: x'=0x7FFFFFFF. Additionally, holding i_valid=0 keeps outputs stable with o_valid=0.
